// File: rtl/mult_div_unit.sv
// Multiply/divide unit holding the HI/LO pair for the E stage (mult, div, mthi/mtlo).
// Latency: mult/multu 5 busy cycles, div/divu 10 busy cycles; mthi/mtlo write on the issuing edge.
// Backpressure: Busy is high while an operation runs; MDU ops arriving while Busy are ignored.
// Optional feature: define MDU_UNSIGNED_EN to enable multu (Op 2) and divu (Op 4).
module mult_div_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  Op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        HiLoSel,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Result
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_q;

  logic        mdu_op;
  logic        is_mult_op;
  logic        signed_op;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic signed [32:0] div_a;
  logic signed [32:0] div_b;
  logic signed [32:0] quot;
  logic signed [32:0] rem;
  logic        div_by_zero;
  logic        unused_div_msb;

  // Decode which opcodes launch a multi-cycle operation in this build.
  always_comb begin
    mdu_op = 1'b0;
    case (Op)
      OP_MULT, OP_DIV: mdu_op = 1'b1;
`ifdef MDU_UNSIGNED_EN
      OP_MULTU, OP_DIVU: mdu_op = 1'b1;
`else
      OP_MULTU, OP_DIVU: mdu_op = 1'b0;
`endif
      default: mdu_op = 1'b0;
    endcase
  end

  assign Start  = mdu_op && !Busy && !Reset;
  assign Result = HiLoSel ? HI : LO;

  // Arithmetic on the captured operands. Extending to 33 bits (sign or zero) lets one
  // signed divider serve both flavours and makes 0x80000000 / -1 yield 0x80000000, rem 0.
  always_comb begin
    is_mult_op  = (op_q == OP_MULT) || (op_q == OP_MULTU);
    signed_op   = (op_q == OP_MULT) || (op_q == OP_DIV);
    mul_a       = signed_op ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
    mul_b       = signed_op ? {{32{op_b[31]}}, op_b} : {32'b0, op_b};
    prod        = mul_a * mul_b;
    div_by_zero = (op_b == 32'b0);
    div_a       = $signed({signed_op & op_a[31], op_a});
    // Substitute 1 for a zero divisor so the divider never sees x; the result is discarded.
    div_b       = div_by_zero ? 33'sd1 : $signed({signed_op & op_b[31], op_b});
    quot        = div_a / div_b;
    rem         = div_a % div_b;
  end

  assign unused_div_msb = quot[32] ^ rem[32];

  // Control FSM: capture on Start, count down in RUN, write HI/LO on the final edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      cnt   <= 4'd0;
      HI    <= 32'b0;
      LO    <= 32'b0;
      op_a  <= 32'b0;
      op_b  <= 32'b0;
      op_q  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op_a  <= D1;
            op_b  <= D2;
            op_q  <= Op;
            cnt   <= ((Op == OP_MULT) || (Op == OP_MULTU)) ? 4'd5 : 4'd10;
            state <= RUN;
            Busy  <= 1'b1;
          end else if (Op == OP_MTHI) begin
            HI <= D1;
          end else if (Op == OP_MTLO) begin
            LO <= D1;
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (is_mult_op) begin
              HI <= prod[63:32];
              LO <= prod[31:0];
            end else if (!div_by_zero) begin
              HI <= rem[31:0];
              LO <= quot[31:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO values and busy timing.
// Latency: checks exactly 5 (mult) / 10 (div) busy cycles after the start edge.
// Backpressure: issues MDU ops and mthi while busy and checks they are ignored.
module tb_mult_div_unit;

  logic        Clock;
  logic        Reset;
  logic [2:0]  Op;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        HiLoSel;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Result;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Op      (Op),
    .D1      (D1),
    .D2      (D2),
    .HiLoSel (HiLoSel),
    .Start   (Start),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO),
    .Result  (Result)
  );

  always #5 Clock = ~Clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Op = 3'd1; D1 = 32'd5; D2 = 32'd6; HiLoSel = 1'b0;
    #1;
    n_checks++;
    if (Start !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", Start); end
    step;
    step;
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    n_checks++;
    if (HI !== 32'h0 || LO !== 32'h0) begin n_fail++; $display("FAIL reset_hilo got=%h_%h exp=0_0", HI, LO); end
    n_checks++;
    if (Result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", Result); end
    Op = 3'd0;
    Reset = 1'b0;
    step;
  endtask

  task automatic test_mult;
    Op = 3'd1; D1 = 32'hFFFFFFFE; D2 = 32'd3;
    #1;
    n_checks++;
    if (Start !== 1'b1) begin n_fail++; $display("FAIL mult_start got=%b exp=1", Start); end
    step;
    Op = 3'd0; D1 = 32'h0; D2 = 32'h0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (Busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy cyc=%0d got=%b exp=1", i, Busy); end
      if (i == 1) begin
        // Attempted restart with new operands while busy must be ignored.
        Op = 3'd1; D1 = 32'd100; D2 = 32'd100;
        #1;
        n_checks++;
        if (Start !== 1'b0) begin n_fail++; $display("FAIL mult_start_busy got=%b exp=0", Start); end
      end
      if (i == 2) begin Op = 3'd0; end
      step;
    end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL mult_done_busy got=%b exp=0", Busy); end
    n_checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
      n_fail++; $display("FAIL mult_result got=%h_%h exp=ffffffff_fffffffa", HI, LO);
    end
  endtask

  task automatic test_multu;
    Op = 3'd2; D1 = 32'hFFFFFFFF; D2 = 32'd2;
    #1;
`ifdef MDU_UNSIGNED_EN
    n_checks++;
    if (Start !== 1'b1) begin n_fail++; $display("FAIL multu_start got=%b exp=1", Start); end
    step;
    Op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (Busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy cyc=%0d got=%b exp=1", i, Busy); end
      step;
    end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL multu_done_busy got=%b exp=0", Busy); end
    n_checks++;
    if (HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL multu_result got=%h_%h exp=00000001_fffffffe", HI, LO);
    end
`else
    n_checks++;
    if (Start !== 1'b0) begin n_fail++; $display("FAIL multu_off_start got=%b exp=0", Start); end
    for (int i = 0; i < 6; i++) begin
      step;
      n_checks++;
      if (Busy !== 1'b0) begin n_fail++; $display("FAIL multu_off_busy cyc=%0d got=%b exp=0", i, Busy); end
    end
    Op = 3'd0;
    n_checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
      n_fail++; $display("FAIL multu_off_hilo got=%h_%h exp=ffffffff_fffffffa", HI, LO);
    end
`endif
  endtask

  task automatic test_div;
    Op = 3'd3; D1 = 32'hFFFFFFF9; D2 = 32'd2;
    step;
    Op = 3'd0; D1 = 32'd77; D2 = 32'd0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (Busy !== 1'b1) begin n_fail++; $display("FAIL div_busy cyc=%0d got=%b exp=1", i, Busy); end
      step;
    end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL div_done_busy got=%b exp=0", Busy); end
    n_checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL div_result got=%h_%h exp=ffffffff_fffffffd", HI, LO);
    end
    // Division by zero: full busy period, HI/LO untouched.
    Op = 3'd3; D1 = 32'd100; D2 = 32'd0;
    step;
    Op = 3'd0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (Busy !== 1'b1) begin n_fail++; $display("FAIL divz_busy cyc=%0d got=%b exp=1", i, Busy); end
      step;
    end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL divz_done_busy got=%b exp=0", Busy); end
    n_checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL divz_hilo got=%h_%h exp=ffffffff_fffffffd", HI, LO);
    end
  endtask

  task automatic test_div_overflow;
    Op = 3'd3; D1 = 32'h80000000; D2 = 32'hFFFFFFFF;
    step;
    Op = 3'd0;
    for (int i = 0; i < 10; i++) step;
    n_checks++;
    if (HI !== 32'h0 || LO !== 32'h80000000) begin
      n_fail++; $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", HI, LO);
    end
  endtask

  task automatic test_divu;
`ifdef MDU_UNSIGNED_EN
    Op = 3'd4; D1 = 32'hFFFFFFF9; D2 = 32'd2;
    step;
    Op = 3'd0;
    for (int i = 0; i < 10; i++) step;
    n_checks++;
    if (HI !== 32'h00000001 || LO !== 32'h7FFFFFFC) begin
      n_fail++; $display("FAIL divu_result got=%h_%h exp=00000001_7ffffffc", HI, LO);
    end
`else
    Op = 3'd4; D1 = 32'hFFFFFFF9; D2 = 32'd2;
    step;
    Op = 3'd0;
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h80000000) begin
      n_fail++; $display("FAIL divu_off got=%b_%h_%h exp=0_00000000_80000000", Busy, HI, LO);
    end
`endif
  endtask

  task automatic test_mtlo_mthi;
    // Clear HI first so the following checks have a known base in both builds.
    Op = 3'd5; D1 = 32'h0;
    step;
    Op = 3'd6; D1 = 32'h12345678; HiLoSel = 1'b0;
    step;
    Op = 3'd0;
    n_checks++;
    if (LO !== 32'h12345678) begin n_fail++; $display("FAIL mtlo got=%h exp=12345678", LO); end
    n_checks++;
    if (Result !== 32'h12345678) begin n_fail++; $display("FAIL mflo_result got=%h exp=12345678", Result); end
    Op = 3'd5; D1 = 32'hCAFEF00D; HiLoSel = 1'b1;
    step;
    Op = 3'd0;
    n_checks++;
    if (Result !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mfhi_result got=%h exp=cafef00d", Result); end
    // mthi while busy is ignored; LO holds until completion.
    Op = 3'd1; D1 = 32'd3; D2 = 32'd4;
    step;
    Op = 3'd5; D1 = 32'hDEADBEEF;
    step;
    Op = 3'd0;
    n_checks++;
    if (HI !== 32'hCAFEF00D || LO !== 32'h12345678) begin
      n_fail++; $display("FAIL mthi_busy_mid got=%h_%h exp=cafef00d_12345678", HI, LO);
    end
    for (int i = 0; i < 4; i++) step;
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'd12) begin
      n_fail++; $display("FAIL mthi_busy_done got=%b_%h_%h exp=0_00000000_0000000c", Busy, HI, LO);
    end
  endtask

  task automatic test_reset_abort;
    Op = 3'd1; D1 = 32'd7; D2 = 32'd6;
    step;
    Op = 3'd0;
    step;
    D1 = 32'd1000; D2 = 32'd1000;
    step;
    Reset = 1'b1; Op = 3'd1;
    #1;
    n_checks++;
    if (Start !== 1'b0) begin n_fail++; $display("FAIL abort_start got=%b exp=0", Start); end
    step;
    Reset = 1'b0; Op = 3'd0;
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      n_fail++; $display("FAIL abort_state got=%b_%h_%h exp=0_00000000_00000000", Busy, HI, LO);
    end
    for (int i = 0; i < 6; i++) begin
      step;
      n_checks++;
      if (Busy !== 1'b0 || LO !== 32'h0) begin
        n_fail++; $display("FAIL abort_no_complete cyc=%0d got=%b_%h exp=0_00000000", i, Busy, LO);
      end
    end
    Op = 3'd1; D1 = 32'd7; D2 = 32'd6;
    step;
    Op = 3'd0;
    for (int i = 0; i < 5; i++) step;
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'd42) begin
      n_fail++; $display("FAIL abort_rerun got=%b_%h_%h exp=0_00000000_0000002a", Busy, HI, LO);
    end
  endtask

  task automatic test_back_to_back;
    // Second mult issues on the edge right after the first completes.
    Op = 3'd1; D1 = 32'hFFFFFFFF; D2 = 32'hFFFFFFFF;
    step;
    for (int i = 0; i < 5; i++) step;
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h1) begin
      n_fail++; $display("FAIL b2b_first got=%b_%h_%h exp=0_00000000_00000001", Busy, HI, LO);
    end
    D1 = 32'h00010000; D2 = 32'h00010000;
    step;
    Op = 3'd0;
    n_checks++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy got=%b exp=1", Busy); end
    for (int i = 0; i < 5; i++) step;
    n_checks++;
    if (HI !== 32'h00000001 || LO !== 32'h0) begin
      n_fail++; $display("FAIL b2b_second got=%h_%h exp=00000001_00000000", HI, LO);
    end
  endtask

  initial begin
    Clock = 1'b0; Reset = 1'b1; Op = 3'd0; D1 = 32'h0; D2 = 32'h0; HiLoSel = 1'b0;
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_overflow;
    test_divu;
    test_mtlo_mthi;
    test_reset_abort;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
